// File: rtl/iram_loader_pkg.sv
// rtl/iram_loader_pkg.sv - shared constants and FSM state encoding for the instruction RAM loader
package iram_loader_pkg;

    localparam int           DEPTH_DEF    = 128;
    localparam int           AW_DEF       = 7;
    localparam logic [7:0]   HDR_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CNT  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CKS  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/iram_loader_store.sv
// rtl/iram_loader_store.sv - DEPTH x 16 instruction store, sync write, async read, sync clear
module iram_loader_store
    import iram_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // Clear every word on reset, otherwise write one word per strobe
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fetch side sees the old word until the write edge has passed
    assign rdata = mem[raddr];

endmodule

// File: rtl/iram_loader.sv
// rtl/iram_loader.sv - byte-stream program loader with checksum and CPU hold control
module iram_loader
    import iram_loader_pkg::*;
#(
    parameter int         DEPTH       = DEPTH_DEF,
    parameter int         AW          = AW_DEF,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    input  logic [7:0]  ADDR,
    output logic [15:0] Q,
    output logic        CPU_HOLD,
    output logic        LOAD_DONE,
    output logic        LOAD_ERR
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    logic [7:0]    nwords;
    logic [7:0]    wcnt;
    logic [7:0]    hi_byte;
    logic [7:0]    sum;
    logic [TW-1:0] timer;

    logic          in_frame;
    logic          timed_out;
    logic          we;
    logic          addr_unused;

    assign in_frame    = (state == ST_CNT) || (state == ST_HI) ||
                         (state == ST_LO)  || (state == ST_CKS);
    // The last idle cycle of the budget is the one that trips the error
    assign timed_out   = in_frame && !RX_VALID && (timer == TW'(TIMEOUT_CYC - 1));
    assign we          = (state == ST_LO) && RX_VALID;
    assign addr_unused = ADDR[0];

    iram_loader_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_store (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (we),
        .waddr (wcnt[AW-1:0]),
        .wdata ({hi_byte, RX_DATA}),
        .raddr (ADDR[AW:1]),
        .rdata (Q)
    );

    // Frame parser: header, count, word bytes, checksum, plus inter-byte timeout
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            CPU_HOLD  <= 1'b1;
            LOAD_DONE <= 1'b0;
            LOAD_ERR  <= 1'b0;
            nwords    <= 8'd0;
            wcnt      <= 8'd0;
            hi_byte   <= 8'd0;
            sum       <= 8'd0;
            timer     <= '0;
        end else begin
            if (RX_VALID || !in_frame) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (RX_VALID && RX_DATA == HDR_BYTE) begin
                        state     <= ST_CNT;
                        CPU_HOLD  <= 1'b1;
                        LOAD_DONE <= 1'b0;
                        LOAD_ERR  <= 1'b0;
                        sum       <= 8'd0;
                        wcnt      <= 8'd0;
                    end
                end
                ST_CNT: begin
                    if (RX_VALID) begin
                        if (RX_DATA == 8'd0 || int'(RX_DATA) > DEPTH) begin
                            state <= ST_ERR;
                        end else begin
                            nwords <= RX_DATA;
                            state  <= ST_HI;
                        end
                    end else if (timed_out) begin
                        state <= ST_ERR;
                    end
                end
                ST_HI: begin
                    if (RX_VALID) begin
                        hi_byte <= RX_DATA;
                        sum     <= sum + RX_DATA;
                        state   <= ST_LO;
                    end else if (timed_out) begin
                        state <= ST_ERR;
                    end
                end
                ST_LO: begin
                    if (RX_VALID) begin
                        sum  <= sum + RX_DATA;
                        wcnt <= wcnt + 8'd1;
                        if (wcnt == nwords - 8'd1) begin
                            state <= ST_CKS;
                        end else begin
                            state <= ST_HI;
                        end
                    end else if (timed_out) begin
                        state <= ST_ERR;
                    end
                end
                ST_CKS: begin
                    if (RX_VALID) begin
                        if (sum + RX_DATA == 8'd0) begin
                            LOAD_DONE <= 1'b1;
                            CPU_HOLD  <= 1'b0;
                        end else begin
                            LOAD_ERR <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (timed_out) begin
                        state <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    LOAD_ERR <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
